// File: rtl/kernel_result_writeback_dual.sv
// kernel_result_writeback_dual
// Two kernel lanes push (index, pixel) results into private FIFOs. A round-robin
// arbiter drains them into one single-port frame memory, at most one write per
// clock. Writes per frame are counted (saturating) and out-of-range indices
// raise a sticky error.

// Per-lane FIFO. Storage is not reset; only the pointers and occupancy are.
module kernel_wb_lane_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt;
  logic          push_ok, pop_ok;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer/occupancy update; a clear drops everything queued.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= din;
  end
endmodule

module kernel_result_writeback_dual #(
  parameter int DATA_W     = 13,
  parameter int IDX_W      = 13,
  parameter int ADDR_W     = 12,
  parameter int NUM_PIXELS = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              frame_clr,
  input  logic              valid1,
  input  logic [IDX_W-1:0]  i1,
  input  logic [DATA_W-1:0] pix1,
  output logic              ready1,
  input  logic              valid2,
  input  logic [IDX_W-1:0]  i2,
  input  logic [DATA_W-1:0] pix2,
  output logic              ready2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              done,
  output logic              range_err
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  localparam int ENT_W = $bits(wb_ent_t);

  logic [NUM_LANES-1:0]             valid, ready, push, pop, full, empty, oor;
  logic [NUM_LANES-1:0][IDX_W-1:0]  idx;
  logic [NUM_LANES-1:0][DATA_W-1:0] pix;
  logic [NUM_LANES-1:0][ENT_W-1:0]  fifo_dout;

  logic    grant_vld;
  logic    grant;       // 0 = lane 1, 1 = lane 2
  logic    last_grant;
  wb_ent_t gsel;

  assign valid  = {valid2, valid1};
  assign idx    = {i2, i1};
  assign pix    = {pix2, pix1};
  assign ready1 = ready[0];
  assign ready2 = ready[1];

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic    in_range;
      wb_ent_t ent;

      // Extra top bit keeps the compare correct even if IDX_W == ADDR_W.
      assign in_range = ({1'b0, idx[l]} < (IDX_W+1)'(NUM_PIXELS));
      // Ready looks only at registered fullness and the clear strobe; a full
      // FIFO stays not-ready even if it is being popped this cycle.
      assign ready[l] = n_rst && !full[l] && !frame_clr;
      assign push[l]  = valid[l] && ready[l] && in_range;
      assign oor[l]   = valid[l] && ready[l] && !in_range;
      assign ent.addr = idx[l][ADDR_W-1:0];
      assign ent.data = pix[l];

      kernel_wb_lane_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (frame_clr),
        .push  (push[l]),
        .din   (ent),
        .pop   (pop[l]),
        .dout  (fifo_dout[l]),
        .full  (full[l]),
        .empty (empty[l])
      );
    end
  endgenerate

  // Round-robin grant from registered FIFO state; ties go to the lane not granted last.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    if (!empty[0] && !empty[1]) begin
      grant_vld = 1'b1;
      grant     = ~last_grant;
    end else if (!empty[0]) begin
      grant_vld = 1'b1;
      grant     = 1'b0;
    end else if (!empty[1]) begin
      grant_vld = 1'b1;
      grant     = 1'b1;
    end
  end

  assign pop  = (grant_vld && !frame_clr) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign gsel = wb_ent_t'(fifo_dout[grant]);
  assign done = (wr_count == (ADDR_W+1)'(NUM_PIXELS));

  // Registered write port, frame counter, sticky range error and arbiter history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      wr_count   <= '0;
      range_err  <= 1'b0;
      last_grant <= 1'b1;   // lane 2 "last" so lane 1 wins the first tie
    end else if (frame_clr) begin
      wr_en      <= 1'b0;
      wr_count   <= '0;
      range_err  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      wr_en <= grant_vld;
      if (grant_vld) begin
        wr_address <= gsel.addr;
        wr_data    <= gsel.data;
        last_grant <= grant;
        if (!done) wr_count <= wr_count + 1'b1;
      end
      if (|oor) range_err <= 1'b1;
    end
  end
endmodule
